// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: bundle of the register-file access signals between the
// decode/writeback side (master) and the register file (slave).
//   wr_en/wr_sel/wr_data  : two write ports, port p packed at slot p
//   rd_sel/rd_data        : NUM_RD read ports, packed per port
//   rd_busy               : per-read-port pending flag of the selected register
//   rsv_en/rsv_sel        : reserve (mark pending) a destination register
//   clr_req/clr_busy/clr_done : sequential clear handshake
interface reg_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int NUM_RD     = 5
);
  localparam int SEL_WIDTH = $clog2(NUM_REGS);

  logic [1:0]                  wr_en;
  logic [2*SEL_WIDTH-1:0]      wr_sel;
  logic [2*DATA_WIDTH-1:0]     wr_data;
  logic [NUM_RD*SEL_WIDTH-1:0] rd_sel;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]           rd_busy;
  logic                        rsv_en;
  logic [SEL_WIDTH-1:0]        rsv_sel;
  logic                        clr_req;
  logic                        clr_busy;
  logic                        clr_done;

  modport master (
    output wr_en, wr_sel, wr_data, rd_sel, rsv_en, rsv_sel, clr_req,
    input  rd_data, rd_busy, clr_busy, clr_done
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, rd_sel, rsv_en, rsv_sel, clr_req,
    output rd_data, rd_busy, clr_busy, clr_done
  );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file.
//   - NUM_RD read ports, each combinational or registered (SYNC_RD_MASK)
//   - two write ports, port 1 wins on a same-register collision, with
//     same-cycle forwarding to the read ports
//   - per-register pending-write scoreboard (reserve from decode, cleared
//     by writeback), reported per read port on rd_busy
//   - software-triggered clear engine zeroing one register per cycle
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : reg_file_mp_if slave modport (see interface header)
module reg_file_mp #(
  parameter int              DATA_WIDTH   = 32,
  parameter int              NUM_REGS     = 16,
  parameter int              NUM_RD       = 5,
  parameter logic [NUM_RD-1:0] SYNC_RD_MASK = 5'b11000,
  parameter bit              ZERO_REG     = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_mp_if.slave  bus
);
  localparam int SEL_WIDTH = $clog2(NUM_REGS);
  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]  regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]    sb_q, sb_d;

  logic [SEL_WIDTH-1:0]   wsel [2];
  logic [DATA_WIDTH-1:0]  wdat [2];
  logic [1:0]             we_eff;
  logic                   rsv_ok;

  logic [SEL_WIDTH-1:0]   rsel [NUM_RD];
  logic [DATA_WIDTH-1:0]  lane_d [NUM_RD];
  logic [NUM_RD-1:0]      hit0, hit1;
  logic [NUM_RD-1:0]      busy;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data_w;

  // Unpack write ports; writes only take effect while the clear engine is idle.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wsel[p]   = bus.wr_sel[p*SEL_WIDTH +: SEL_WIDTH];
      wdat[p]   = bus.wr_data[p*DATA_WIDTH +: DATA_WIDTH];
      we_eff[p] = bus.wr_en[p] && (state_q == ST_IDLE) &&
                  !(ZERO_REG && (wsel[p] == '0));
    end
    rsv_ok = bus.rsv_en && (state_q != ST_CLEAR) &&
             !(ZERO_REG && (bus.rsv_sel == '0));
  end

  // Read lanes: forwarding from this cycle's effective writes (port 1 first),
  // then the array. Busy is masked when the pending write lands this cycle.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rsel[i] = bus.rd_sel[i*SEL_WIDTH +: SEL_WIDTH];
      hit1[i] = we_eff[1] && (wsel[1] == rsel[i]);
      hit0[i] = we_eff[0] && (wsel[0] == rsel[i]);
      if (hit1[i]) begin
        lane_d[i] = wdat[1];
      end else if (hit0[i]) begin
        lane_d[i] = wdat[0];
      end else if (ZERO_REG && (rsel[i] == '0)) begin
        lane_d[i] = '0;
      end else begin
        lane_d[i] = regs_q[rsel[i]];
      end
      busy[i] = sb_q[rsel[i]] && !(hit0[i] || hit1[i]);
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_lane
    if (SYNC_RD_MASK[i]) begin : g_sync
      logic [DATA_WIDTH-1:0] lane_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_q <= '0;
        end else begin
          lane_q <= lane_d[i];
        end
      end
      assign rd_data_w[i*DATA_WIDTH +: DATA_WIDTH] = lane_q;
    end else begin : g_async
      assign rd_data_w[i*DATA_WIDTH +: DATA_WIDTH] = lane_d[i];
    end
  end

  assign bus.rd_data  = rd_data_w;
  assign bus.rd_busy  = busy;
  assign bus.clr_busy = (state_q == ST_CLEAR);
  assign bus.clr_done = (state_q == ST_DONE);

  // Next-state: array, scoreboard and clear FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    regs_d  = regs_q;
    sb_d    = sb_q;

    // Port 1 applied last so it overrides port 0 on the same register.
    for (int p = 0; p < 2; p++) begin
      if (we_eff[p]) begin
        regs_d[wsel[p]] = wdat[p];
        sb_d[wsel[p]]   = 1'b0;
      end
    end
    // Reservation after the write clear: a new producer outranks the old one.
    if (rsv_ok) begin
      sb_d[bus.rsv_sel] = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        regs_d[idx_q] = '0;
        idx_d         = idx_q + SEL_WIDTH'(1);
        if (idx_q == LAST_IDX) begin
          sb_d    = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      sb_q    <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sb_q    <= sb_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed test of reg_file_mp with default parameters
// (32x16, lanes 0-2 combinational, lanes 3-4 registered, ZERO_REG=1).
module tb_reg_file_mp;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int ND = 5;
  localparam int SW = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   busy_cnt;
  int   done_cnt;

  reg_file_mp_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(ND)) bus ();

  reg_file_mp #(
    .DATA_WIDTH   (DW),
    .NUM_REGS     (NR),
    .NUM_RD       (ND),
    .SYNC_RD_MASK (5'b11000),
    .ZERO_REG     (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.wr_en   = 2'b00;
    bus.rsv_en  = 1'b0;
    bus.clr_req = 1'b0;
  endtask

  task automatic set_rd(input int lane, input int sel);
    logic [SW-1:0] s;
    s = SW'(sel);
    bus.rd_sel[lane*SW +: SW] = s;
  endtask

  task automatic set_all_rd(input int sel);
    for (int i = 0; i < ND; i++) set_rd(i, sel);
  endtask

  task automatic write_p(input int p, input int sel, input logic [31:0] d);
    logic [SW-1:0] s;
    s = SW'(sel);
    bus.wr_en[p]              = 1'b1;
    bus.wr_sel[p*SW +: SW]    = s;
    bus.wr_data[p*DW +: DW]   = d;
  endtask

  function automatic logic [31:0] lane(input int i);
    return bus.rd_data[i*DW +: DW];
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.wr_en   = '0;
    bus.wr_sel  = '0;
    bus.wr_data = '0;
    bus.rd_sel  = '0;
    bus.rsv_en  = 1'b0;
    bus.rsv_sel = '0;
    bus.clr_req = 1'b0;

    // Reset state
    tick();
    tick();
    set_rd(0, 3);
    set_rd(3, 3);
    #1;
    chk("rst_lane0", lane(0), 32'h0);
    chk("rst_lane3", lane(3), 32'h0);
    chk("rst_lane4", lane(4), 32'h0);
    chk("rst_clr_busy", 32'(bus.clr_busy), 32'h0);
    chk("rst_clr_done", 32'(bus.clr_done), 32'h0);
    chk("rst_busy", 32'(bus.rd_busy), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic write with forwarding and sync-lane latency
    write_p(0, 3, 32'hDEADBEEF);
    #1;
    chk("fwd_async_lane0", lane(0), 32'hDEADBEEF);
    chk("sync_lane3_before", lane(3), 32'h0);
    tick();
    idle_in();
    #1;
    chk("array_lane0", lane(0), 32'hDEADBEEF);
    chk("sync_lane3_after", lane(3), 32'hDEADBEEF);

    // Write-port collision: port 1 wins
    write_p(0, 5, 32'h11111111);
    write_p(1, 5, 32'h22222222);
    set_all_rd(5);
    #1;
    chk("coll_lane0", lane(0), 32'h22222222);
    chk("coll_lane1", lane(1), 32'h22222222);
    chk("coll_lane2", lane(2), 32'h22222222);
    tick();
    idle_in();
    #1;
    chk("coll_array", lane(0), 32'h22222222);
    chk("coll_sync3", lane(3), 32'h22222222);
    chk("coll_sync4", lane(4), 32'h22222222);

    // Two writes to different registers both land
    write_p(0, 6, 32'hAAAA0006);
    write_p(1, 8, 32'hBBBB0008);
    tick();
    idle_in();
    set_rd(0, 6);
    set_rd(1, 8);
    #1;
    chk("dual_reg6", lane(0), 32'hAAAA0006);
    chk("dual_reg8", lane(1), 32'hBBBB0008);

    // Zero register ignores writes and reservations
    write_p(0, 0, 32'hFFFFFFFF);
    bus.rsv_en  = 1'b1;
    bus.rsv_sel = 4'd0;
    set_all_rd(0);
    #1;
    chk("zero_fwd", lane(0), 32'h0);
    tick();
    idle_in();
    #1;
    chk("zero_lane0", lane(0), 32'h0);
    chk("zero_lane3", lane(3), 32'h0);
    chk("zero_busy0", 32'(bus.rd_busy[0]), 32'h0);
    chk("zero_busy3", 32'(bus.rd_busy[3]), 32'h0);

    // Scoreboard
    bus.rsv_en  = 1'b1;
    bus.rsv_sel = 4'd7;
    set_rd(0, 7);
    set_rd(4, 7);
    #1;
    chk("sb_not_yet", 32'(bus.rd_busy[0]), 32'h0);
    tick();
    idle_in();
    #1;
    chk("sb_set_l0", 32'(bus.rd_busy[0]), 32'h1);
    chk("sb_set_l4", 32'(bus.rd_busy[4]), 32'h1);
    write_p(0, 7, 32'h12345678);
    #1;
    chk("sb_wr_mask", 32'(bus.rd_busy[0]), 32'h0);
    chk("sb_wr_fwd", lane(0), 32'h12345678);
    tick();
    idle_in();
    #1;
    chk("sb_cleared", 32'(bus.rd_busy[0]), 32'h0);
    bus.rsv_en  = 1'b1;
    bus.rsv_sel = 4'd7;
    write_p(1, 7, 32'hCAFEF00D);
    tick();
    idle_in();
    #1;
    chk("sb_set_wins", 32'(bus.rd_busy[0]), 32'h1);
    chk("sb_set_data", lane(0), 32'hCAFEF00D);

    // Clear engine
    for (int r = 1; r < NR; r++) begin
      write_p(0, r, 32'h10000000 + 32'(r));
      tick();
      idle_in();
    end
    bus.rsv_en  = 1'b1;
    bus.rsv_sel = 4'd9;
    tick();
    idle_in();
    set_rd(0, 9);
    set_rd(1, 15);
    #1;
    chk("pre_clr_busy9", 32'(bus.rd_busy[0]), 32'h1);
    chk("pre_clr_reg9", lane(0), 32'h10000009);
    chk("pre_clr_reg15", lane(1), 32'h1000000F);
    bus.clr_req = 1'b1;
    #1;
    chk("clr_busy_idle", 32'(bus.clr_busy), 32'h0);
    tick();
    bus.clr_req = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      bus.wr_en  = 2'b00;
      bus.rsv_en = 1'b0;
      if (c == 5) begin
        write_p(0, 2, 32'h55555555);
        bus.rsv_en  = 1'b1;
        bus.rsv_sel = 4'd3;
        set_rd(0, 2);
        #1;
        chk("clr_no_fwd", lane(0), 32'h0);
      end
      if (bus.clr_busy) busy_cnt++;
      if (bus.clr_done) done_cnt++;
      tick();
    end
    idle_in();
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd16);
    chk("clr_done_pulses", 32'(done_cnt), 32'd1);
    for (int r = 0; r < NR; r++) begin
      set_rd(0, r);
      #1;
      chk($sformatf("clr_reg%0d", r), lane(0), 32'h0);
      chk($sformatf("clr_busy%0d", r), 32'(bus.rd_busy[0]), 32'h0);
    end

    // Reset in the middle of a clear
    tick();
    write_p(0, 12, 32'hCCCCCCCC);
    bus.rsv_en  = 1'b1;
    bus.rsv_sel = 4'd13;
    set_all_rd(12);
    set_rd(1, 13);
    tick();
    idle_in();
    #1;
    chk("mid_pre_sync3", lane(3), 32'hCCCCCCCC);
    chk("mid_pre_busy13", 32'(bus.rd_busy[1]), 32'h1);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    repeat (5) tick();
    chk("mid_clr_busy", 32'(bus.clr_busy), 32'h1);
    chk("mid_sync3_held", lane(3), 32'hCCCCCCCC);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_clr_busy", 32'(bus.clr_busy), 32'h0);
    chk("mid_rst_clr_done", 32'(bus.clr_done), 32'h0);
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("mid_rst_lane%0d", i), lane(i), 32'h0);
    end
    chk("mid_rst_busy", 32'(bus.rd_busy), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.clr_req = 1'b1;
    #1;
    chk("re_clr_idle", 32'(bus.clr_busy), 32'h0);
    tick();
    bus.clr_req = 1'b0;
    chk("re_clr_busy", 32'(bus.clr_busy), 32'h1);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.clr_done) done_cnt++;
      tick();
    end
    chk("re_clr_done", 32'(done_cnt), 32'd1);
    chk("re_clr_end_busy", 32'(bus.clr_busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file, successor to the fixed 16x32 three-port file. Configurable width, depth and read-port count, plus:
- per-port sync/async read selection
- two prioritised write ports with forwarding
- per-register pending-write scoreboard for hazard detection
- sequential software-triggered clear engine

Sits between decode (reads, reservations) and writeback (writes) in the core pipeline.

Parameters:
DATA_WIDTH, 32, bits per register
NUM_REGS, 16, register count (power of two, >=2)
SEL_WIDTH, $clog2(NUM_REGS), register select width (derived, not overridden)
NUM_RD, 5, number of read ports (1..8)
SYNC_RD_MASK, 5'b11000, bit i=1: read port i registered; bit i=0: read port i combinational
ZERO_REG, 1, 1: register 0 reads 0, ignores writes and reservations

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  2  write enables, port 1 has priority
wr_sel  in  2*SEL_WIDTH  write selects, port p at [p*SEL_WIDTH +: SEL_WIDTH]
wr_data  in  2*DATA_WIDTH  write data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
rd_sel  in  NUM_RD*SEL_WIDTH  read selects, packed per port
rd_data  out  NUM_RD*DATA_WIDTH  read data, packed per port
rd_busy  out  NUM_RD  scoreboard pending flag of selected register
rsv_en  in  1  mark rsv_sel pending
rsv_sel  in  SEL_WIDTH  register to reserve
clr_req  in  1  start sequential clear (level, sampled in IDLE)
clr_busy  out  1  clear in progress
clr_done  out  1  one-cycle pulse on clear completion

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers 0, scoreboard 0, FSM IDLE, clear index 0
  - registered rd_data lanes 0, clr_busy 0, clr_done 0
- Effective write on port p: wr_en[p] && FSM==IDLE && !(ZERO_REG && wr_sel_p==0).
- Both write ports effective to the same register: port 1 data stored, port 0 discarded. Different registers: both stored.
- Write latency: data visible in array on the cycle after the edge.
- Forwarding, read port i:
  - If any effective write targets rd_sel_i this cycle, lane returns that write data (port 1 if both hit).
  - Otherwise lane returns the array value; register 0 returns 0 when ZERO_REG.
- Read timing:
  - Async lane (mask bit 0): combinational from the forwarding result.
  - Sync lane (mask bit 1): forwarding result captured at the edge, 1-cycle latency.
- Scoreboard:
  - rsv_en sets sb[rsv_sel] unless ZERO_REG && rsv_sel==0.
  - Any effective write clears sb[wr_sel].
  - Reserve and write to the same register in the same cycle: set wins (new producer).
- rd_busy[i] = sb[rd_sel_i] && !(effective write hitting rd_sel_i this cycle). Combinational for all lanes, regardless of mask.
- Clear FSM:
  - IDLE: clr_req=1 -> CLEAR, index 0, clr_busy=1 next cycle.
  - CLEAR: each cycle write 0 to reg[index], index++; writes and reservations ignored (not stored, scoreboard untouched by them); reads return current array contents, no forwarding of clear writes.
  - CLEAR, index==NUM_REGS-1: write that register, zero whole scoreboard -> DONE.
  - DONE: clr_done=1 for exactly this cycle, clr_busy=0, -> IDLE.
  - clr_req held high re-triggers from IDLE on the following cycle.
  - clr_req in CLEAR or DONE is ignored.
  - Total: NUM_REGS cycles busy, then 1 done cycle.
- Reset asserted mid-clear: FSM returns to IDLE immediately; registers and scoreboard are zeroed by reset.
- Select values are always in range (power-of-two depth), so no out-of-range handling is required.

Test Plan:
- Basic, defaults: write reg 3=0xDEADBEEF on port 0 -> async lane 0 (sel 3) shows 0xDEADBEEF same cycle (forwarded) and next cycle (array); sync lane 3 (sel 3) shows it one cycle later.
- Write-port collision: same cycle, port 0 writes reg 5=0x11111111 and port 1 writes reg 5=0x22222222 -> all lanes reading 5 return 0x22222222; array holds 0x22222222 afterwards.
- Zero register: write reg 0=0xFFFFFFFF, rsv_en with sel 0 -> reads of reg 0 return 0; rd_busy 0 on any lane selecting reg 0.
- Scoreboard: rsv reg 7 -> rd_busy=1 next cycle. Write reg 7 -> rd_busy=0 in the write cycle. Same-cycle rsv+write reg 7 -> rd_busy=1 afterwards, data updated.
- Clear: fill all 16 regs with nonzero values, reserve reg 9, pulse clr_req -> clr_busy high 16 cycles; write to reg 2 during clear is dropped; clr_done pulses once; all regs read 0; rd_busy 0 everywhere.
- Reset mid-clear: deassert rst_n at cycle 6 of clear -> clr_busy=0 immediately, all lanes 0. After release, the FSM accepts a new clr_req.
